// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, load-use hold
// and saturating stall counter for the 5-stage MIPS core.
module ex_operand_stage #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_dest,
    input  logic [W-1:0]     id_rs_val,
    input  logic [W-1:0]     id_rt_val,
    input  logic [W-1:0]     id_imm,
    input  logic             id_use_imm,
    input  logic [3:0]       id_alu_op,
    input  logic             id_is_load,
    input  logic             id_is_store,
    input  logic [1:0]       fwd_a,
    input  logic [1:0]       fwd_b,
    input  logic             stop,
    input  logic [W-1:0]     mem_fwd_data,
    input  logic [W-1:0]     wb_fwd_data,
    input  logic             flush,
    output logic             ex_valid,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_dest,
    output logic [3:0]       ex_alu_op,
    output logic             ex_is_load,
    output logic             ex_is_store,
    output logic [W-1:0]     ex_op_a,
    output logic [W-1:0]     ex_op_b,
    output logic [W-1:0]     ex_store_data,
    output logic             id_hold,
    output logic             ex_to_mem_valid,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [W-1:0] rs_val_q;
    logic [W-1:0] rt_val_q;
    logic [W-1:0] imm_q;
    logic         use_imm_q;
    logic [W-1:0] fa;
    logic [W-1:0] fb;
    logic         hold;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        fa = rs_val_q;
        fb = rt_val_q;
        case (fwd_a)
            2'd1:    fa = mem_fwd_data;
            2'd2:    fa = wb_fwd_data;
            default: fa = rs_val_q;
        endcase
        case (fwd_b)
            2'd1:    fb = mem_fwd_data;
            2'd2:    fb = wb_fwd_data;
            default: fb = rt_val_q;
        endcase
    end

    assign hold            = stop & ex_valid;
    assign id_hold         = hold;
    assign ex_to_mem_valid = ex_valid & ~stop & ~flush;
    assign ex_op_a         = fa;
    assign ex_store_data   = fb;
    assign ex_op_b         = use_imm_q ? imm_q : fb;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_dest     <= '0;
            ex_alu_op   <= '0;
            ex_is_load  <= 1'b0;
            ex_is_store <= 1'b0;
            use_imm_q   <= 1'b0;
            rs_val_q    <= '0;
            rt_val_q    <= '0;
            imm_q       <= '0;
            stall_cnt   <= '0;
        end else if (flush) begin
            // Bubble: zero indices keep the forwarding unit from matching it.
            ex_valid    <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_dest     <= '0;
            ex_alu_op   <= '0;
            ex_is_load  <= 1'b0;
            ex_is_store <= 1'b0;
            use_imm_q   <= 1'b0;
        end else if (hold) begin
            // Refresh operands so a WB forward survives its writer retiring.
            rs_val_q <= fa;
            rt_val_q <= fb;
            if (stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
        end else begin
            ex_valid    <= id_valid;
            ex_rs       <= id_valid ? id_rs : 5'd0;
            ex_rt       <= id_valid ? id_rt : 5'd0;
            ex_dest     <= id_valid ? id_dest : 5'd0;
            ex_alu_op   <= id_valid ? id_alu_op : 4'd0;
            ex_is_load  <= id_valid & id_is_load;
            ex_is_store <= id_valid & id_is_store;
            use_imm_q   <= id_valid & id_use_imm;
            rs_val_q    <= id_rs_val;
            rt_val_q    <= id_rt_val;
            imm_q       <= id_imm;
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed-vector bench for ex_operand_stage: pass-through, forwarding,
// immediate select, load-use hold, flush, counter saturation and reset.
module tb_ex_operand_stage;

    localparam int W     = 32;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs, id_rt, id_dest;
    logic [W-1:0]     id_rs_val, id_rt_val, id_imm;
    logic             id_use_imm;
    logic [3:0]       id_alu_op;
    logic             id_is_load, id_is_store;
    logic [1:0]       fwd_a, fwd_b;
    logic             stop;
    logic [W-1:0]     mem_fwd_data, wb_fwd_data;
    logic             flush;
    logic             ex_valid;
    logic [4:0]       ex_rs, ex_rt, ex_dest;
    logic [3:0]       ex_alu_op;
    logic             ex_is_load, ex_is_store;
    logic [W-1:0]     ex_op_a, ex_op_b, ex_store_data;
    logic             id_hold, ex_to_mem_valid;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    ex_operand_stage #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
        .id_is_load(id_is_load), .id_is_store(id_is_store),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stop(stop),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data), .flush(flush),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_alu_op(ex_alu_op), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_store_data(ex_store_data),
        .id_hold(id_hold), .ex_to_mem_valid(ex_to_mem_valid), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [W-1:0] rsv,
                            input logic [4:0] rt, input logic [W-1:0] rtv, input logic [4:0] dst,
                            input logic [W-1:0] imm, input logic ui, input logic ld, input logic st);
        id_valid = v;   id_rs = rs;  id_rs_val = rsv; id_rt = rt; id_rt_val = rtv;
        id_dest = dst;  id_imm = imm; id_use_imm = ui; id_is_load = ld; id_is_store = st;
        id_alu_op = 4'd2;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; stop = 1'b1;
        fwd_a = 2'd0; fwd_b = 2'd0; mem_fwd_data = '0; wb_fwd_data = '0;
        drive_id(1'b1, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        // Reset state, with stop asserted on an empty EX slot.
        check("rst_valid", ex_valid, 0);
        check("rst_hold_ignores_stop", id_hold, 0);
        check("rst_op_a", ex_op_a, 0);
        check("rst_cnt", stall_cnt, 0);
        stop = 1'b0;
        rst  = 1'b1;

        // Pass-through.
        drive_id(1'b1, 5'd3, 32'h11, 5'd4, 32'h22, 5'd5, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        check("pt_valid", ex_valid, 1);
        check("pt_rs", ex_rs, 3);
        check("pt_rt", ex_rt, 4);
        check("pt_dest", ex_dest, 5);
        check("pt_load", ex_is_load, 1);
        check("pt_op_a", ex_op_a, 32'h11);
        check("pt_op_b", ex_op_b, 32'h22);
        check("pt_to_mem", ex_to_mem_valid, 1);

        // Forward select, same cycle.
        fwd_a = 2'd1; mem_fwd_data = 32'hAAAA;
        fwd_b = 2'd2; wb_fwd_data  = 32'hBBBB;
        settle();
        check("fw_op_a_mem", ex_op_a, 32'hAAAA);
        check("fw_op_b_wb", ex_op_b, 32'hBBBB);
        check("fw_store_wb", ex_store_data, 32'hBBBB);
        fwd_a = 2'd3; fwd_b = 2'd0;
        settle();
        check("fw_sel3_reg", ex_op_a, 32'h11);

        // Immediate vs store data.
        drive_id(1'b1, 5'd6, 32'h1, 5'd7, 32'h99, 5'd0, 32'h10, 1'b1, 1'b0, 1'b1);
        fwd_a = 2'd0; fwd_b = 2'd0;
        tick();
        fwd_b = 2'd1; mem_fwd_data = 32'h55;
        settle();
        check("imm_op_b", ex_op_b, 32'h10);
        check("imm_store", ex_store_data, 32'h55);
        check("imm_is_store", ex_is_store, 1);

        // Load-use stall.
        drive_id(1'b1, 5'd8, 32'h30, 5'd9, 32'h40, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0);
        fwd_b = 2'd0;
        tick();
        drive_id(1'b1, 5'd1, 32'hDEAD, 5'd2, 32'hBEEF, 5'd13, 32'h0, 1'b0, 1'b0, 1'b0);
        stop = 1'b1;
        settle();
        check("lu1_id_hold", id_hold, 1);
        check("lu1_to_mem", ex_to_mem_valid, 0);
        tick();
        stop = 1'b0; fwd_a = 2'd2; wb_fwd_data = 32'h77;
        settle();
        check("lu2_rs_kept", ex_rs, 8);
        check("lu2_dest_kept", ex_dest, 12);
        check("lu2_op_a", ex_op_a, 32'h77);
        check("lu2_op_b_refreshed", ex_op_b, 32'h40);
        check("lu2_to_mem", ex_to_mem_valid, 1);
        check("lu2_id_hold", id_hold, 0);
        check("lu2_cnt", stall_cnt, 1);

        // Held operand whose WB source retires mid-stall.
        drive_id(1'b1, 5'd10, 32'h0, 5'd11, 32'h5, 5'd14, 32'h0, 1'b0, 1'b0, 1'b0);
        fwd_a = 2'd0;
        tick();
        stop = 1'b1; fwd_a = 2'd2; wb_fwd_data = 32'hCAFE;
        tick();
        stop = 1'b0; fwd_a = 2'd0; wb_fwd_data = 32'h0;
        settle();
        check("retire_op_a", ex_op_a, 32'hCAFE);
        check("retire_rs", ex_rs, 10);
        check("retire_cnt", stall_cnt, 2);

        // Flush during stall.
        stop = 1'b1; flush = 1'b1;
        settle();
        check("fl_id_hold", id_hold, 1);
        check("fl_to_mem", ex_to_mem_valid, 0);
        tick();
        flush = 1'b0; stop = 1'b0;
        settle();
        check("fl_valid", ex_valid, 0);
        check("fl_rs", ex_rs, 0);
        check("fl_rt", ex_rt, 0);
        check("fl_cnt", stall_cnt, 2);

        // Invalid capture zeroes the indices.
        drive_id(1'b0, 5'd5, 32'h1, 5'd6, 32'h2, 5'd7, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        check("bub_valid", ex_valid, 0);
        check("bub_rs", ex_rs, 0);
        check("bub_dest", ex_dest, 0);
        check("bub_load", ex_is_load, 0);

        // Saturation then reset mid-stall.
        drive_id(1'b1, 5'd15, 32'h3, 5'd16, 32'h4, 5'd17, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        stop = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("sat_cnt", stall_cnt, 3);
        check("sat_rs_kept", ex_rs, 15);
        rst = 1'b0;
        tick();
        check("rst2_valid", ex_valid, 0);
        check("rst2_id_hold", id_hold, 0);
        check("rst2_to_mem", ex_to_mem_valid, 0);
        check("rst2_cnt", stall_cnt, 0);
        check("rst2_rs", ex_rs, 0);
        check("rst2_op_a", ex_op_a, 0);
        check("rst2_op_b", ex_op_b, 0);
        check("rst2_store", ex_store_data, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register plus EX-stage operand selection for the 5-stage MIPS core. It captures decoded instructions from ID and presents the registered source indices `ex_rs`/`ex_rt` to the forwarding unit. It applies the returned forward selects to build the ALU operands and store data. On a load-use stop it holds the EX instruction, freezes ID, and tells MEM to take a bubble.

## Interface
- `W`, default 32: data width.
- `CNT_W`, default 16: stall-counter width.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `id_valid`  in  1  ID holds a valid instruction.
- `id_rs`, `id_rt`, `id_dest`  in  5 each  source/destination register indices.
- `id_rs_val`, `id_rt_val`  in  W each  register-file read data.
- `id_imm`  in  W  extended immediate.
- `id_use_imm`  in  1  operand B is the immediate.
- `id_alu_op`  in  4  ALU opcode.
- `id_is_load`, `id_is_store`  in  1 each  memory-op flags.
- `fwd_a`, `fwd_b`  in  2 each  forward selects: 0 = register, 1 = MEM, 2 = WB, 3 = register.
- `stop`  in  1  load-use hazard from the forwarding unit.
- `mem_fwd_data`, `wb_fwd_data`  in  W each  forwarded results.
- `flush`  in  1  kill the EX instruction (branch/exception).
- `ex_valid`  out  1  EX holds a valid instruction.
- `ex_rs`, `ex_rt`  out  5 each  registered sources, routed to the forwarding unit.
- `ex_dest`  out  5  registered destination.
- `ex_alu_op`  out  4  registered ALU opcode.
- `ex_is_load`, `ex_is_store`  out  1 each  registered memory-op flags.
- `ex_op_a`, `ex_op_b`, `ex_store_data`  out  W each  final operands.
- `id_hold`  out  1  freeze PC and IF/ID.
- `ex_to_mem_valid`  out  1  EX result is valid for MEM this cycle.
- `stall_cnt`  out  CNT_W  saturating count of hold cycles.

## Operation
- **Forwarded values (combinational).**
  - `fa` = `mem_fwd_data` if `fwd_a`=1, `wb_fwd_data` if `fwd_a`=2, otherwise the registered rs value.
  - `fb` is formed the same way from `fwd_b` and the registered rt value.
- **Operands.**
  - `ex_op_a` = `fa`.
  - `ex_store_data` = `fb`.
  - `ex_op_b` = registered immediate if the registered use_imm flag is 1, otherwise `fb`.
- **Hold condition.** `hold` = `stop` & `ex_valid`.
  - `id_hold` = `hold`.
  - `ex_to_mem_valid` = `ex_valid` & ~`stop` & ~`flush`.
- **Register update on each rising edge, priority order:**
  1. `rst`=0: every register cleared; `ex_valid`=0, `stall_cnt`=0.
  2. `flush`=1: `ex_valid`←0; `ex_rs`, `ex_rt`, `ex_dest` ← 0; flags ← 0; `stall_cnt` unchanged.
  3. `hold`: instruction fields kept. The rs value register ← `fa` and the rt value register ← `fb` (operand refresh), so data forwarded from WB is not lost when that writer retires during the stall. `stall_cnt` += 1, saturating at all-ones.
  4. Otherwise, capture from ID: `ex_valid`←`id_valid`. If `id_valid`=0, the indices and flags load 0 and the data fields are don't-care.
- **Bubble rules.**
  - An invalid slot always shows `ex_rs`=`ex_rt`=`ex_dest`=0, so the forwarding unit never forwards or stops on a bubble.
  - `stop` with `ex_valid`=0 is ignored.
- **Flush vs stop.** `flush` overrides `stop` in the same cycle; `id_hold` still reflects `stop`, and the IF/ID flush logic elsewhere owns ID.

## Timing
- ID→EX latency: 1 cycle.
- `ex_op_*`, `ex_store_data`, `id_hold`, `ex_to_mem_valid`: combinational from registers and the current forwarding inputs; no added latency.
- Load-use case: `stop` is high for exactly one cycle per dependency, since the next cycle the load is in WB and `fwd`=2.
  - The EX instruction therefore occupies EX for 2 cycles.
  - MEM sees `ex_to_mem_valid`=0 in the first cycle.
- Back-to-back hold cycles: each refreshes the operands and increments `stall_cnt`.
- Reset mid-stall: the next cycle has `ex_valid`=0 and `id_hold`=0.
- Reset values: all outputs 0 (combinational outputs are 0 because `ex_valid`=0, indices are 0 and data registers are 0).

## Test plan
- **Pass-through:** `id_valid`=1, rs=3 val 0x11, rt=4 val 0x22, `fwd`=0 → next cycle `ex_valid`=1, `ex_rs`=3, `ex_op_a`=0x11, `ex_op_b`=0x22.
- **Forward select:** `fwd_a`=1 with `mem_fwd_data`=0xAAAA, `fwd_b`=2 with `wb_fwd_data`=0xBBBB → `ex_op_a`=0xAAAA, `ex_op_b`=0xBBBB, same cycle.
- **Immediate vs store data:** `id_use_imm`=1, imm=0x10, `fwd_b`=1, `mem_fwd_data`=0x55 → `ex_op_b`=0x10, `ex_store_data`=0x55.
- **Load-use stall:**
  - Cycle 1: `stop`=1, `ex_valid`=1 → `id_hold`=1, `ex_to_mem_valid`=0.
  - Cycle 2: `fwd_a`=2, `wb_fwd_data`=0x77, `stop`=0 → EX fields unchanged, `ex_op_a`=0x77, `ex_to_mem_valid`=1, `stall_cnt`=1.
  - Separately, a held operand whose WB source retires mid-stall still shows its forwarded value.
- **Flush during stall:** `stop`=1, `flush`=1 → next cycle `ex_valid`=0, `ex_rs`=0, `stall_cnt` unchanged.
- **Saturation/reset:** with `CNT_W`=2, hold 5 cycles → `stall_cnt`=3. Then `rst`=0 for one edge → every output 0.
